// File: rtl/smith_waterman_pkg.sv
// smith_waterman_pkg: shared types, defaults and completion-word layout for the Smith-Waterman AFU
package smith_waterman_pkg;
  localparam int HC_ADDR_W = 42;
  localparam int BUF_SIZE_W = 32;
  localparam int MAX_OUTSTANDING_DEF = 64;
  localparam int MDATA_W = 16;
  localparam int CW_DONE_BIT = 63;
  localparam int CW_COUNT_W = 63;
  typedef logic [HC_ADDR_W-1:0] t_hc_address;
  typedef logic [BUF_SIZE_W-1:0] t_buf_size;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WR, S_WR_WAIT} t_sched_state;
  function automatic logic [63:0] completion_word(input logic [CW_COUNT_W-1:0] count);
    logic [63:0] w;
    w = '0;
    w[CW_DONE_BIT] = 1'b1;
    w[CW_COUNT_W-1:0] = count;
    return w;
  endfunction
endpackage

// File: rtl/smith_waterman_rr_arb.sv
// smith_waterman_rr_arb: N-way round-robin arbiter, searching from the entry after the last grant
module smith_waterman_rr_arb #(
  parameter int N = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [N-1:0]     elig,
  input  logic             adv,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] last, ci;
  int c;
  // walk from farthest to nearest so the nearest eligible entry after last wins
  always_comb begin
    idx = '0;
    c = 0;
    ci = '0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(last) + k) % N;
      ci = IDX_W'(c);
      if (elig[ci]) idx = ci;
    end
    grant = (|elig) ? (N'(1) << idx) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset || clr) last <= IDX_W'(N - 1);
    else if (adv) last <= idx;
  end
endmodule

// File: rtl/smith_waterman_rd_sched.sv
// smith_waterman_rd_sched: walks the buffer table issuing c0 line reads round-robin under a credit limit,
// drains outstanding reads, then posts the completion word to the DSM line.
module smith_waterman_rd_sched
  import smith_waterman_pkg::*;
#(
  parameter int NUM_BUF = 2,
  parameter int ADDR_W = $bits(t_hc_address),
  parameter int SIZE_W = $bits(t_buf_size),
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                dsm_base,
  input  logic [NUM_BUF-1:0][ADDR_W-1:0]   buf_addr,
  input  logic [NUM_BUF-1:0][SIZE_W-1:0]   buf_size,
  output logic                             rd_req_valid,
  output logic [ADDR_W-1:0]                rd_req_addr,
  output logic [MDATA_W-1:0]               rd_req_mdata,
  input  logic                             rd_almfull,
  input  logic                             rd_rsp_valid,
  output logic                             wr_req_valid,
  output logic [ADDR_W-1:0]                wr_req_addr,
  output logic [63:0]                      wr_req_data,
  input  logic                             wr_almfull,
  input  logic                             wr_ack,
  output logic                             busy,
  output logic                             done
);
  localparam int IDX_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int OST_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int OFF_W = MDATA_W - IDX_W;
  localparam int TOT_W = SIZE_W + IDX_W;

  t_sched_state state, state_n;
  logic [ADDR_W-1:0] sh_addr [NUM_BUF];
  logic [SIZE_W-1:0] sh_size [NUM_BUF];
  logic [SIZE_W-1:0] offset [NUM_BUF];
  logic [ADDR_W-1:0] sh_dsm;
  logic [OST_W-1:0] outstanding;
  logic [TOT_W-1:0] total;
  logic [NUM_BUF-1:0] elig, grant;
  logic [IDX_W-1:0] idx;
  logic any, launch, issue, wr_fire, rsp_dec;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_BUF; i++) elig[i] = offset[i] < sh_size[i];
  end

  smith_waterman_rr_arb #(.N(NUM_BUF), .IDX_W(IDX_W)) u_arb (
    .clk(clk),
    .reset(reset),
    .clr(launch),
    .elig(elig),
    .adv(issue),
    .grant(grant),
    .idx(idx)
  );

  assign any = |grant;

  always_comb begin
    launch = (state == S_IDLE) && start;
    issue = (state == S_ISSUE) && any && !rd_almfull && (outstanding < OST_W'(MAX_OUTSTANDING));
    wr_fire = (state == S_WR) && !wr_almfull;
    // floor at zero: responses with nothing outstanding (e.g. after a mid-job reset) are dropped
    rsp_dec = rd_rsp_valid && (outstanding != '0);
    state_n = state;
    case (state)
      S_IDLE:    state_n = start ? S_ISSUE : S_IDLE;
      S_ISSUE:   state_n = any ? S_ISSUE : S_DRAIN;
      S_DRAIN:   state_n = (outstanding == '0) ? S_WR : S_DRAIN;
      S_WR:      state_n = wr_fire ? S_WR_WAIT : S_WR;
      S_WR_WAIT: state_n = wr_ack ? S_IDLE : S_WR_WAIT;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      total <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr <= '0;
      rd_req_mdata <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr <= '0;
      wr_req_data <= '0;
      sh_dsm <= '0;
      for (int i = 0; i < NUM_BUF; i++) begin
        sh_addr[i] <= '0;
        sh_size[i] <= '0;
        offset[i] <= '0;
      end
    end else begin
      rd_req_valid <= issue;
      wr_req_valid <= wr_fire;
      outstanding <= outstanding + OST_W'(issue) - OST_W'(rsp_dec);
      if (launch) begin
        sh_dsm <= dsm_base;
        outstanding <= '0;
        total <= '0;
        done <= 1'b0;
        busy <= 1'b1;
        for (int i = 0; i < NUM_BUF; i++) begin
          sh_addr[i] <= buf_addr[i];
          sh_size[i] <= buf_size[i];
          offset[i] <= '0;
        end
      end
      if (issue) begin
        rd_req_addr <= sh_addr[idx] + ADDR_W'(offset[idx]);
        rd_req_mdata <= {idx, offset[idx][OFF_W-1:0]};
        offset[idx] <= offset[idx] + SIZE_W'(1);
        total <= total + TOT_W'(1);
      end
      if (wr_fire) begin
        wr_req_addr <= sh_dsm;
        wr_req_data <= completion_word(CW_COUNT_W'(total));
      end
      if (state == S_WR_WAIT && wr_ack) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_smith_waterman_rd_sched.sv
// tb_smith_waterman_rd_sched: scoreboard bench for the read scheduler, credit limit of 4
module tb_smith_waterman_rd_sched;
  logic clk = 1'b0;
  logic reset, start, rd_almfull, rd_rsp_valid, wr_almfull, wr_ack;
  logic [41:0] dsm_base;
  logic [1:0][41:0] buf_addr;
  logic [1:0][31:0] buf_size;
  logic rd_req_valid, wr_req_valid, busy, done;
  logic [41:0] rd_req_addr, wr_req_addr;
  logic [15:0] rd_req_mdata;
  logic [63:0] wr_req_data;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, n_rd = 0, n_wr = 0, pend = 0, wr_cyc = 0, wr_run = 0, max_run = 0;
  logic auto_rsp = 1'b0, rsp_once = 1'b0, ack_due = 1'b0;
  logic [41:0] exp_dsm = '0;
  logic [63:0] exp_rd [$];
  logic [63:0] exp_wr [$];

  smith_waterman_rd_sched #(.NUM_BUF(2), .ADDR_W(42), .SIZE_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dsm_base(dsm_base),
    .buf_addr(buf_addr), .buf_size(buf_size),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_almfull(rd_almfull), .rd_rsp_valid(rd_rsp_valid),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_almfull(wr_almfull), .wr_ack(wr_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic rsp;
    logic [63:0] e;
    rsp = (auto_rsp || rsp_once) && pend > 0;
    rd_rsp_valid = rsp;
    wr_ack = ack_due;
    ack_due = 1'b0;
    rsp_once = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (rsp) pend--;
    if (rd_req_valid) begin
      e = (exp_rd.size() != 0) ? exp_rd.pop_front() : '1;
      check("rd_req", {6'd0, rd_req_addr, rd_req_mdata}, e);
      n_rd++;
      pend++;
    end
    if (wr_req_valid) begin
      e = (exp_wr.size() != 0) ? exp_wr.pop_front() : '0;
      check("wr_addr", 64'(wr_req_addr), 64'(exp_dsm));
      check("wr_data", wr_req_data, e);
      n_wr++;
      wr_cyc = cyc;
      ack_due = 1'b1;
    end
    wr_run = wr_req_valid ? wr_run + 1 : 0;
    if (wr_run > max_run) max_run = wr_run;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      step();
      i++;
    end
    check("done", 64'(done), 64'd1);
    check("busy_clear", 64'(busy), 64'd0);
  endtask

  // sets the buffer table and pushes the expected round-robin read order
  task automatic job(input logic [41:0] a0, input int s0, input logic [41:0] a1, input int s1,
                     input logic [41:0] dsm, input bit want_wr);
    logic [41:0] a [2];
    int s [2];
    int off [2];
    int last, c, nx, tot;
    a[0] = a0; a[1] = a1; s[0] = s0; s[1] = s1;
    off[0] = 0; off[1] = 0;
    last = 1; tot = 0;
    buf_addr[0] = a0; buf_addr[1] = a1;
    buf_size[0] = 32'(s0); buf_size[1] = 32'(s1);
    dsm_base = dsm;
    exp_dsm = dsm;
    while (off[0] < s[0] || off[1] < s[1]) begin
      nx = (last + 1) % 2;
      c = (off[nx] < s[nx]) ? nx : last;
      exp_rd.push_back({6'd0, a[c] + 42'(off[c]), c[0], 15'(off[c])});
      off[c]++;
      last = c;
      tot++;
    end
    if (want_wr) exp_wr.push_back({1'b1, 63'(tot)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, w0, r0;
    reset = 1'b1; start = 1'b0; rd_almfull = 1'b0; rd_rsp_valid = 1'b0;
    wr_almfull = 1'b0; wr_ack = 1'b0; dsm_base = '0; buf_addr = '0; buf_size = '0;
    run(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_valid", 64'(rd_req_valid), 64'd0);
    check("rst_wr_valid", 64'(wr_req_valid), 64'd0);
    check("rst_rd_addr", 64'(rd_req_addr), 64'd0);
    check("rst_wr_data", wr_req_data, 64'd0);
    reset = 1'b0;
    run(2);

    // two buffers, no backpressure; inputs scrambled after start to prove the shadow copy
    job(42'h1000, 3, 42'h2000, 2, 42'h3_F000, 1);
    auto_rsp = 1'b1;
    pulse_start();
    check("lat_cycle1", 64'(rd_req_valid), 64'd0);
    check("busy_set", 64'(busy), 64'd1);
    buf_addr[0] = 42'h5555; buf_addr[1] = 42'h6666; buf_size = '0; dsm_base = 42'h1;
    step();
    check("lat_cycle2", 64'(rd_req_valid), 64'd1);
    wait_done(200);
    check("t1_reads", 64'(n_rd), 64'd5);
    check("t1_writes", 64'(n_wr), 64'd1);

    // both sizes zero
    r0 = n_rd; w0 = n_wr;
    job(42'h1000, 0, 42'h2000, 0, 42'h3_F010, 1);
    s = cyc;
    pulse_start();
    wait_done(50);
    check("zero_reads", 64'(n_rd - r0), 64'd0);
    check("zero_wr_cnt", 64'(n_wr - w0), 64'd1);
    check("zero_wr_lat", 64'((wr_cyc - s) <= 4), 64'd1);

    // credit limit with responses withheld
    auto_rsp = 1'b0;
    r0 = n_rd;
    job(42'h0A00, 10, 42'h0B00, 0, 42'h3_F020, 1);
    pulse_start();
    run(10);
    check("credit_stall", 64'(n_rd - r0), 64'd4);
    for (int j = 0; j < 6; j++) begin
      rsp_once = 1'b1;
      run(4);
      check("credit_release", 64'(n_rd - r0), 64'(5 + j));
    end
    auto_rsp = 1'b1;
    wait_done(100);
    check("credit_total", 64'(n_rd - r0), 64'd10);

    // rd_almfull window, then a response coinciding with the first issue after it
    auto_rsp = 1'b0;
    r0 = n_rd;
    job(42'h1_0000, 8, 42'h2_0000, 8, 42'h3_F030, 1);
    pulse_start();
    run(2);
    check("af_pre", 64'(n_rd - r0), 64'd2);
    rd_almfull = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j == 10) rsp_once = 1'b1;
      step();
    end
    check("af_hold", 64'(n_rd - r0), 64'd2);
    rd_almfull = 1'b0;
    rsp_once = 1'b1;
    step();
    check("af_resume", 64'(n_rd - r0), 64'd3);
    run(10);
    check("af_credit", 64'(n_rd - r0), 64'd6);
    auto_rsp = 1'b1;
    wait_done(200);
    check("af_total", 64'(n_rd - r0), 64'd16);

    // second start while busy, then reset during DRAIN with 3 reads outstanding
    auto_rsp = 1'b0;
    r0 = n_rd; w0 = n_wr;
    job(42'h5000, 3, 42'h6000, 0, 42'h3_F040, 0);
    pulse_start();
    pulse_start();
    run(6);
    check("abort_reads", 64'(n_rd - r0), 64'd3);
    check("abort_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    check("abort_rst_busy", 64'(busy), 64'd0);
    check("abort_rst_done", 64'(done), 64'd0);
    run(5);
    auto_rsp = 1'b1;
    run(6);
    check("abort_no_wr", 64'(n_wr - w0), 64'd0);
    check("abort_late_rsp", 64'(pend), 64'd0);
    r0 = n_rd;
    job(42'h3000, 2, 42'h4000, 1, 42'h3_F050, 1);
    pulse_start();
    wait_done(100);
    check("clean_reads", 64'(n_rd - r0), 64'd3);
    check("clean_wr", 64'(n_wr - w0), 64'd1);

    // wr_almfull held when WR is reached
    w0 = n_wr;
    max_run = 0;
    wr_almfull = 1'b1;
    job(42'h7000, 1, 42'h8000, 1, 42'h3_F060, 1);
    pulse_start();
    run(15);
    check("wraf_hold", 64'(n_wr - w0), 64'd0);
    check("wraf_busy", 64'(busy), 64'd1);
    wr_almfull = 1'b0;
    wait_done(50);
    check("wraf_wr", 64'(n_wr - w0), 64'd1);
    check("wraf_pulse", 64'(max_run), 64'd1);

    run(3);
    check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/smith_waterman_rd_sched.md
Name: smith_waterman_rd_sched

Overview:
- Read-request scheduler and job sequencer for the Smith-Waterman AFU.
- On a start command from the CSR block, it walks every configured host buffer (base address and size in cache lines) and issues one CCI-P c0 cache-line read per line, interleaving buffers round-robin.
- It tracks outstanding reads, then posts a completion write to the DSM line.
- Sits between the CSR block (control, DSM base, buffer table) and the c0/c1 TX arbitration toward the FIU.

Parameters:
- NUM_BUF, 2, number of buffer-table entries scheduled.
- ADDR_W, 42, cache-line address width.
- SIZE_W, 32, buffer size width in cache lines.
- MAX_OUTSTANDING, 64, read credit limit; power of two, at most 2^(16-IDX_W).
- IDX_W, $clog2(NUM_BUF) (minimum 1), buffer index width in mdata.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle start pulse, decoded from the CSR control register
- dsm_base  in  ADDR_W  DSM cache-line address
- buf_addr  in  NUM_BUF x ADDR_W  per-buffer base cache-line address
- buf_size  in  NUM_BUF x SIZE_W  per-buffer length in lines
- rd_req_valid  out  1  read request valid
- rd_req_addr  out  ADDR_W  read cache-line address
- rd_req_mdata  out  16  {buffer index, line offset low bits}
- rd_almfull  in  1  c0TxAlmFull
- rd_rsp_valid  in  1  read response received
- wr_req_valid  out  1  DSM write valid
- wr_req_addr  out  ADDR_W  DSM write address
- wr_req_data  out  64  completion word
- wr_almfull  in  1  c1TxAlmFull
- wr_ack  in  1  c1 write response
- busy  out  1  job in progress
- done  out  1  sticky, set at completion, cleared by start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Inputs are ignored during reset.
- FSM states: IDLE, ISSUE, DRAIN, WR, WR_WAIT.
- IDLE:
  - On start, latch buf_addr, buf_size and dsm_base into shadow registers.
  - Clear per-buffer offsets, outstanding count, total count and done; set busy.
  - Go to ISSUE.
- start while busy is ignored.
- ISSUE:
  - Each cycle where rd_almfull=0, outstanding<MAX_OUTSTANDING and an eligible buffer exists (offset<size), assert rd_req_valid for exactly one cycle.
  - Address is shadow addr[i] + offset[i]; mdata = {i, offset[i] low bits}. Then offset[i]++, outstanding++, total++.
  - Arbitration: round-robin starting after the last granted index; exhausted buffers are skipped.
  - Peak rate is one request per cycle.
  - When no buffer is eligible, go to DRAIN. If all sizes are 0, go straight to DRAIN.
- Outstanding counter:
  - Decrements on rd_rsp_valid.
  - A simultaneous issue and response leaves it unchanged.
  - It never goes below 0; a stray response at 0 is ignored.
- DRAIN: when outstanding==0, go to WR.
- WR:
  - Assert wr_req_valid for one cycle when wr_almfull=0, with wr_req_addr=dsm_base and wr_req_data={1'b1, total[62:0]}.
  - Then go to WR_WAIT.
- WR_WAIT: on wr_ack, set done, clear busy, go to IDLE.
- Almfull asserted mid-job: issue stalls, with no request lost or duplicated.
- Reset mid-job returns to IDLE with counters cleared. Responses arriving afterwards are absorbed by the floor-at-0 rule.
- Latency: first rd_req_valid appears 2 cycles after start (latch cycle, then issue cycle).
- Widths: offsets are SIZE_W; total is SIZE_W+IDX_W; the addr+offset sum is truncated to ADDR_W.

Decomposition:
- Package smith_waterman_pkg holds:
  - t_sched_state enum.
  - MAX_OUTSTANDING default.
  - A completion-word bit-layout constant (bit 63 = done, [62:0] = line count).
- t_hc_address and the buffer typedefs are reused from the package.
- One sub-module: smith_waterman_rr_arb, a parameterised NUM_BUF-way round-robin arbiter.
  - Inputs: eligible mask, advance strobe.
  - Output: one-hot grant plus index.

Test Plan:
- Two buffers, addr0=0x1000 size 3, addr1=0x2000 size 2, no backpressure:
  - Required read addresses in order: 0x1000, 0x2000, 0x1001, 0x2001, 0x1002.
  - After 5 responses, one DSM write to dsm_base with data 0x8000_0000_0000_0005; done=1 after wr_ack.
- Both sizes 0:
  - No read issued.
  - DSM write with data 0x8000_0000_0000_0000 within 4 cycles of start.
- Credit limit, MAX_OUTSTANDING=4, size0=10, responses withheld:
  - Exactly 4 requests issued, then stall.
  - Each response releases exactly one more request.
  - Total issued is 10.
- rd_almfull held high for 20 cycles mid-job, with a response and an issue opportunity in the same cycle:
  - No requests while almfull is high.
  - Sequence resumes without gap or duplicate.
  - Outstanding stays unchanged on the simultaneous cycle.
- A second start while busy, then reset asserted during DRAIN with 3 reads outstanding:
  - The second start is ignored.
  - After reset: busy=0, done=0, no DSM write.
  - The 3 late responses are ignored, and a new start runs a clean job.
- wr_almfull high when entering WR:
  - wr_req_valid is held off until it deasserts, then asserted for exactly one cycle.
